// File: rtl/guia_1102_tx.sv
// guia_1102_tx: bit-serial frame transmitter.
// Sends a fixed preamble and then a latched payload word, MSB first,
// one bit per clock. The serial line idles low between frames.
module guia_1102_tx #(
    parameter int                DATA_W   = 8,
    parameter int                PRE_W    = 4,
    parameter logic [PRE_W-1:0]  PREAMBLE = 4'b1010
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              x,
    output logic              ready,
    output logic              busy,
    output logic              done
);

    localparam int TOTAL = PRE_W + DATA_W;
    localparam int CW    = $clog2(TOTAL) + 1;

    // cnt_q holds the number of frame bits already placed on the line
    localparam logic [CW-1:0] LAST_C = CW'(TOTAL);
    localparam logic [CW-1:0] PRE_C  = CW'(PRE_W);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [TOTAL-1:0]   frame_q, frame_d;
    logic               x_q, x_d;
    logic [TOTAL-1:0]   load_w;

    // Whole frame (preamble followed by payload) as one MSB-first word
    assign load_w = {PREAMBLE, data_in};

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Shift register, bit counter and registered serial line
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            frame_q <= '0;
            x_q     <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            x_q     <= x_d;
        end
    end

    // Next-state: the state names which part of the frame x is showing
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_PRE;
                end
            end
            S_PRE, S_DATA: begin
                if (cnt_q == LAST_C) begin
                    state_d = S_DONE;
                end else if (cnt_q >= PRE_C) begin
                    state_d = S_DATA;
                end else begin
                    state_d = S_PRE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath next values: the first bit goes out on the accepting edge,
    // the remaining bits are shifted out of the captured copy
    always_comb begin
        cnt_d   = cnt_q;
        frame_d = frame_q;
        x_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d     = load_w[TOTAL-1];
                    frame_d = {load_w[TOTAL-2:0], 1'b0};
                    cnt_d   = ONE_C;
                end else begin
                    cnt_d   = '0;
                end
            end
            S_PRE, S_DATA: begin
                if (cnt_q != LAST_C) begin
                    x_d     = frame_q[TOTAL-1];
                    frame_d = {frame_q[TOTAL-2:0], 1'b0};
                    cnt_d   = cnt_q + ONE_C;
                end else begin
                    frame_d = '0;
                    cnt_d   = '0;
                end
            end
            S_DONE: begin
                cnt_d = '0;
            end
            default: begin
                cnt_d   = '0;
                frame_d = '0;
            end
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        x     = x_q;
        ready = (state_q == S_IDLE);
        busy  = (state_q != S_IDLE);
        done  = (state_q == S_DONE);
    end

endmodule

// File: tb/tb_guia_1102_tx.sv
// Testbench for guia_1102_tx: directed frames plus randomized frames with
// spurious start/data_in activity, checked against a frame-level model.
module tb_guia_1102_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       x, ready, busy, done;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    guia_1102_tx #(
        .DATA_W  (8),
        .PRE_W   (4),
        .PREAMBLE(4'b1010)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .data_in(data_in),
        .x      (x),
        .ready  (ready),
        .busy   (busy),
        .done   (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: frame bit k is preamble bit k (MSB first) then payload bit k-4
    function automatic logic exp_bit(input logic [7:0] d, input int k);
        logic [3:0] pre;
        pre = 4'b1010;
        if (k < 4) return pre[3-k];
        return d[7-(k-4)];
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, ".x"},     {31'b0, x},     32'd0);
        chk({tag, ".ready"}, {31'b0, ready}, 32'd1);
        chk({tag, ".busy"},  {31'b0, busy},  32'd0);
        chk({tag, ".done"},  {31'b0, done},  32'd0);
    endtask

    task automatic chk_bit(input string tag, input int k, input logic e);
        string t;
        t = $sformatf("%s.bit%0d", tag, k);
        chk({t, ".x"},     {31'b0, x},     {31'b0, e});
        chk({t, ".ready"}, {31'b0, ready}, 32'd0);
        chk({t, ".busy"},  {31'b0, busy},  32'd1);
        chk({t, ".done"},  {31'b0, done},  32'd0);
    endtask

    task automatic chk_done(input string tag);
        chk({tag, ".done.x"},     {31'b0, x},     32'd0);
        chk({tag, ".done.ready"}, {31'b0, ready}, 32'd0);
        chk({tag, ".done.busy"},  {31'b0, busy},  32'd1);
        chk({tag, ".done.done"},  {31'b0, done},  32'd1);
    endtask

    // Bits from..11 of a frame already in flight; noise drives random start
    // and data_in, pulse_at raises start for one bit time only
    task automatic run_bits(input string tag, input logic [7:0] d, input int from,
                            input bit noise, input int pulse_at);
        for (int k = from; k < 12; k++) begin
            if (noise) begin
                start   = 1'($urandom_range(0, 1));
                data_in = 8'($urandom);
            end else begin
                start = (k == pulse_at);
            end
            tick();
            chk_bit(tag, k, exp_bit(d, k));
        end
    endtask

    // Full frame from IDLE, through DONE, and one more idle cycle
    task automatic send(input string tag, input logic [7:0] d, input bit noise,
                        input int pulse_at);
        start   = 1'b1;
        data_in = d;
        tick();
        chk_bit(tag, 0, exp_bit(d, 0));
        if (!noise) data_in = ~d;
        run_bits(tag, d, 1, noise, pulse_at);
        start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
        chk_done(tag);
        start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
        chk_idle({tag, ".after"});
        start = 1'b0;
        tick();
        chk_idle({tag, ".quiet"});
    endtask

    initial begin
        // Reset then idle
        #1 reset = 1'b0;
        #1 chk_idle("reset");
        #2 reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_idle($sformatf("idle%0d", i));
        end

        // Single frame
        send("frameA5", 8'hA5, 1'b0, -1);

        // Start pulsed at bit 6 is ignored
        send("ignFF", 8'hFF, 1'b0, 6);

        // Back-to-back frames with start held high
        start   = 1'b1;
        data_in = 8'h3C;
        tick();
        chk_bit("b2b3C", 0, exp_bit(8'h3C, 0));
        data_in = 8'hC3;
        for (int k = 1; k < 12; k++) begin
            tick();
            chk_bit("b2b3C", k, exp_bit(8'h3C, k));
        end
        tick();
        chk_done("b2b3C");
        tick();
        chk_idle("b2bgap");
        tick();
        chk_bit("b2bC3", 0, exp_bit(8'hC3, 0));
        start = 1'b0;
        run_bits("b2bC3", 8'hC3, 1, 1'b0, -1);
        tick();
        chk_done("b2bC3");
        tick();
        chk_idle("b2bC3.after");

        // Reset during the data phase
        start   = 1'b1;
        data_in = 8'h5A;
        tick();
        start = 1'b0;
        chk_bit("rst5A", 0, exp_bit(8'h5A, 0));
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk_bit("rst5A", k, exp_bit(8'h5A, k));
        end
        reset = 1'b0;
        #1 chk_idle("rst.async");
        tick();
        chk_idle("rst.held");
        #4 reset = 1'b1;
        tick();
        chk_idle("rst.released");
        tick();
        chk_idle("rst.released2");
        send("after_rst5A", 8'h5A, 1'b0, -1);

        // Randomized frames with spurious inputs while busy
        for (int n = 0; n < 25; n++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                data_in = 8'($urandom);
                tick();
                chk_idle($sformatf("gap%0d", n));
            end
            send($sformatf("rnd%0d", n), 8'($urandom), 1'b1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/guia_1102_tx.md
Name: guia_1102_tx

Overview:
- Bit-serial frame transmitter, the sending end of the "1010" sequence-detector link.
- On a start request it latches one data word. It then emits a fixed preamble (default 1010) followed by the word, MSB first, one bit per clock on a single serial line.
- The receiving detector FSM samples the line on the same clock; the transmitter guarantees the line idles low between frames.

Parameters:
- DATA_W, 8, width of the payload word shifted out after the preamble (legal range 1..16).
- PRE_W, 4, number of preamble bits.
- PREAMBLE, 4'b1010, preamble pattern, sent MSB first; width equals PRE_W.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (reset=0 forces reset state immediately).
- start  input  1  frame request; sampled on rising clk, accepted only while ready=1.
- data_in  input  DATA_W  payload word; captured on the same edge that accepts start.
- x  output  1  serial line (registered); 0 when idle.
- ready  output  1  1 only in IDLE; the block can accept start.
- busy  output  1  1 in PRE, DATA and DONE.
- done  output  1  one-cycle pulse in DONE state (frame complete).

Behaviour:
- All outputs are registered or decoded from registered state only; there is no combinational path from start or data_in to any output.
- Reset (reset=0, asynchronous):
  - state=IDLE, x=0, ready=1, busy=0, done=0.
  - Shift register and bit counter cleared.
- States: IDLE, PRE, DATA, DONE (2-bit encoding; unused codes return to IDLE).
- IDLE:
  - x=0, ready=1.
  - start=1 at edge E0 → latch data_in, go to PRE; x shows PREAMBLE[PRE_W-1] after E0.
  - start=0 → stay in IDLE.
- PRE:
  - Each bit is held exactly one clock.
  - After edges E0..E(PRE_W-1), x shows PREAMBLE bits MSB→LSB.
  - After the last preamble bit → DATA.
- DATA:
  - After edges E(PRE_W)..E(PRE_W+DATA_W-1), x shows data bits MSB→LSB, from the captured copy.
  - After the last data bit → DONE.
- DONE:
  - Lasts exactly one cycle: x=0, done=1, busy=1, ready=0.
  - Next edge → IDLE.
- Frame length: PRE_W+DATA_W bit-cycles, plus 1 DONE cycle. Defaults: 12 bits, done asserted after edge E12, ready=1 after E13.
- Back-to-back frames: start held high through DONE is accepted at the first edge in IDLE. This guarantees a minimum of 2 idle-low cycles (DONE + IDLE) between frames.
- start while busy=1: ignored; it is neither queued nor counted.
- data_in changes after acceptance: no effect on the frame in flight.
- Bit counter width: clog2(PRE_W+DATA_W)+1; no wrap within a frame.
- Reset asserted mid-frame: immediate abort to IDLE, x=0, no done pulse, payload discarded. After reset releases, the next start begins a full frame, preamble included.
- done and ready are never high in the same cycle.
- busy == !ready at all times.

Test Plan:
- Reset then idle: reset=0 for 3 time units, release, start=0 for 5 clocks → x=0, ready=1, busy=0, done=0 throughout.
- Single frame: data_in=8'hA5, start=1 for one clock → x sequence 1,0,1,0, 1,0,1,0,0,1,0,1 on 12 consecutive clocks, then done=1 for one clock with x=0, then ready=1.
- Loopback: feed x into guia_1101 (same clk/reset), data_in=8'h00 → detector y goes 1 after the preamble (4th bit plus one cycle) and stays locked.
- Ignored start: start pulsed at bit 6 of a frame carrying 8'hFF → the frame is unchanged (1010 then 8 ones), exactly one done pulse, no second frame.
- Back-to-back: start held high, data_in=8'h3C then 8'hC3 → two full frames separated by exactly 2 clocks of x=0, one done pulse per frame.
- Mid-frame reset: reset=0 during the data phase of 8'h5A → x=0 and ready=1 immediately (before the next clk edge), done never asserts. A new start with 8'h5A then produces the full 12-bit frame.
